// File: rtl/spi_resp_pkg.sv
// Shared types and widths for the SPI register responder.
// Frame state encoding and command-byte field positions.
package spi_resp_pkg;

    typedef enum logic [2:0] {
        CMD,
        WDATA,
        RCOUNT,
        RDATA,
        DONE
    } spi_resp_state_t;

    localparam int SPI_WRITE_BIT = 7;
    localparam int SPI_ADDR_W    = 7;

endpackage

// File: rtl/spi_edge_sync.sv
// 2-flop synchronizer with an edge register; rise/fall pulses valid 2 clk after the pad edge.
// No backpressure: one-cycle pulses, the consumer must take them when they occur.
module spi_edge_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign q_o    = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_reg_responder.sv
// SPI write/burst-read responder serving an 8-bit register bank; actions land 3 clk after the pad sclk edge.
// No backpressure: the initiator owns timing, and a frame ends after TIMEOUT idle clk cycles.
module spi_reg_responder
    import spi_resp_pkg::*;
#(
    parameter int                    NUM_REGS    = 16,
    parameter logic [SPI_ADDR_W-1:0] INST_ADDR   = 7'h02,
    parameter logic [SPI_ADDR_W-1:0] STATUS_ADDR = 7'h03,
    parameter int                    TIMEOUT     = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  pico,
    input  logic [7:0]            status_in,
    output logic                  poci,
    output logic [NUM_REGS*8-1:0] reg_q,
    output logic [7:0]            inst_pulse,
    output logic                  wr_strobe,
    output logic [SPI_ADDR_W-1:0] wr_addr,
    output logic                  frame_abort,
    output logic                  busy
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic pico_s, pico_rise, pico_fall;
    logic unused_sync;

    spi_edge_sync #(.WIDTH(1)) u_sclk_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (sclk),
        .q_o    (sclk_lvl),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_edge_sync #(.WIDTH(1)) u_pico_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (pico),
        .q_o    (pico_s),
        .rise_o (pico_rise),
        .fall_o (pico_fall)
    );

    assign unused_sync = ^{sclk_lvl, pico_rise, pico_fall};

    spi_resp_state_t       state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [6:0]            shift_in_q, shift_in_d;
    logic [SPI_ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]            count_q, count_d;
    logic [7:0]            shift_out_q, shift_out_d;
    logic                  poci_q, poci_d;
    logic                  busy_q, busy_d;
    logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic [7:0]            inst_q, inst_d;
    logic                  wr_strobe_q, wr_strobe_d;
    logic [SPI_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic                  abort_q, abort_d;
    logic [7:0]            regs_q [NUM_REGS];

    logic [7:0]            byte_in;
    logic                  byte_done;
    logic                  sclk_edge;
    logic                  tmo_hit;
    logic                  addr_in_range;
    logic [IDX_W-1:0]      reg_idx;
    logic [7:0]            rd_byte;

    assign byte_in       = {shift_in_q, pico_s};
    assign byte_done     = sclk_rise && (bit_cnt_q == 3'd7) && (state_q != DONE);
    assign sclk_edge     = sclk_rise | sclk_fall;
    // A detected edge in the expiry cycle keeps the frame alive.
    assign tmo_hit       = busy_q && !sclk_edge && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
    assign addr_in_range = int'(addr_q) < NUM_REGS;
    assign reg_idx       = addr_q[IDX_W-1:0];

    always_comb begin
        rd_byte = '0;
        if (addr_q == STATUS_ADDR) begin
            rd_byte = status_in;
        end else if (addr_q != INST_ADDR && addr_in_range) begin
            rd_byte = regs_q[reg_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CMD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tmo_hit) begin
            state_d = CMD;
        end else if (byte_done) begin
            case (state_q)
                CMD:     state_d = byte_in[SPI_WRITE_BIT] ? WDATA : RCOUNT;
                WDATA:   state_d = DONE;
                RCOUNT:  state_d = (byte_in == 8'd0) ? DONE : RDATA;
                RDATA:   state_d = (count_q == 8'd1) ? DONE : RDATA;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        addr_d      = addr_q;
        count_d     = count_q;
        shift_out_d = shift_out_q;
        poci_d      = poci_q;
        busy_d      = busy_q;
        inst_d      = '0;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        abort_d     = 1'b0;
        tmo_cnt_d   = (!busy_q || sclk_edge || tmo_hit) ? '0 : tmo_cnt_q + TMO_W'(1);

        if (tmo_hit) begin
            bit_cnt_d = '0;
            busy_d    = 1'b0;
            poci_d    = 1'b0;
            abort_d   = !((state_q == DONE) || (state_q == CMD && bit_cnt_q == 3'd0));
        end else begin
            if (sclk_rise) begin
                busy_d = 1'b1;
            end
            if (sclk_rise && state_q != DONE) begin
                shift_in_d = byte_in[6:0];
                bit_cnt_d  = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    case (state_q)
                        CMD:    addr_d = byte_in[SPI_ADDR_W-1:0];
                        WDATA: begin
                            if (addr_q == INST_ADDR) begin
                                inst_d = byte_in;
                            end else if (addr_q != STATUS_ADDR && addr_in_range) begin
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = addr_q;
                            end
                        end
                        RCOUNT: count_d = byte_in;
                        RDATA:  count_d = count_q - 8'd1;
                        default: ;
                    endcase
                end
            end
            // Byte boundary fall loads the next read byte and drives its MSB straight away.
            if (sclk_fall && state_q == RDATA) begin
                if (bit_cnt_q == 3'd0) begin
                    poci_d      = rd_byte[7];
                    shift_out_d = {rd_byte[6:0], 1'b0};
                    addr_d      = addr_q + 7'd1;
                end else begin
                    poci_d      = shift_out_q[7];
                    shift_out_d = {shift_out_q[6:0], 1'b0};
                end
            end
            if (state_d != RDATA) begin
                poci_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            addr_q      <= '0;
            count_q     <= '0;
            shift_out_q <= '0;
            poci_q      <= 1'b0;
            busy_q      <= 1'b0;
            tmo_cnt_q   <= '0;
            inst_q      <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            abort_q     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            shift_out_q <= shift_out_d;
            poci_q      <= poci_d;
            busy_q      <= busy_d;
            tmo_cnt_q   <= tmo_cnt_d;
            inst_q      <= inst_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            abort_q     <= abort_d;
            if (wr_strobe_d) begin
                regs_q[reg_idx] <= byte_in;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q[g*8 +: 8] = regs_q[g];
    end

    assign poci        = poci_q;
    assign inst_pulse  = inst_q;
    assign wr_strobe   = wr_strobe_q;
    assign wr_addr     = wr_addr_q;
    assign frame_abort = abort_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed bench for spi_reg_responder: writes, instruction pulses, burst reads, timeout abort and reset.
module tb_spi_reg_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         sclk;
    logic         pico;
    logic [7:0]   status_in;
    logic         poci;
    logic [127:0] reg_q;
    logic [7:0]   inst_pulse;
    logic         wr_strobe;
    logic [6:0]   wr_addr;
    logic         frame_abort;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int inst_cnt = 0;
    int abort_cnt = 0;
    logic [7:0] inst_last = 8'h00;

    spi_reg_responder dut (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk),
        .pico        (pico),
        .status_in   (status_in),
        .poci        (poci),
        .reg_q       (reg_q),
        .inst_pulse  (inst_pulse),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr),
        .frame_abort (frame_abort),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) wr_cnt++;
        if (inst_pulse != 8'h00) begin
            inst_cnt++;
            inst_last = inst_pulse;
        end
        if (frame_abort) abort_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SPI bit: 4 clk low (poci sampled at the end), then 4 clk high.
    task automatic spi_bit(input logic b, output logic r);
        pico = b;
        repeat (4) @(negedge clk);
        r = poci;
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], rx[i]);
        end
    endtask

    task automatic wr_frame(input logic [7:0] cmd, input logic [7:0] dat);
        logic [7:0] rx;
        spi_byte(cmd, rx);
        spi_byte(dat, rx);
    endtask

    initial begin
        logic [127:0] exp_regs;
        logic [7:0]   rx;
        logic         rb;
        logic [7:0]   exp_rd [5];
        int w0, i0, a0;

        rst = 1'b1;
        sclk = 1'b0;
        pico = 1'b0;
        status_in = 8'h00;
        exp_regs = '0;
        idle(5);
        check("rst_reg_q", reg_q, 128'h0);
        check("rst_poci", poci, 0);
        check("rst_inst", inst_pulse, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_abort", frame_abort, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        idle(5);

        // Write 0xF0 to register 1
        w0 = wr_cnt;
        a0 = abort_cnt;
        wr_frame(8'h81, 8'hF0);
        exp_regs[15:8] = 8'hF0;
        check("wr1_byte", reg_q[15:8], 8'hF0);
        check("wr1_all", reg_q, exp_regs);
        check("wr1_strobes", wr_cnt - w0, 1);
        check("wr1_addr", wr_addr, 7'd1);
        check("wr1_busy_in_done", busy, 1);
        idle(100);
        check("wr1_busy_after", busy, 0);
        check("wr1_no_abort", abort_cnt - a0, 0);

        // Instruction pulse
        w0 = wr_cnt;
        i0 = inst_cnt;
        wr_frame(8'h82, 8'h03);
        check("inst_cycles", inst_cnt - i0, 1);
        check("inst_value", inst_last, 8'h03);
        check("inst_no_strobe", wr_cnt - w0, 0);
        check("inst_regs", reg_q, exp_regs);
        idle(100);

        // Preload 4..7 and 0
        wr_frame(8'h84, 8'h11); idle(100);
        wr_frame(8'h85, 8'h22); idle(100);
        wr_frame(8'h86, 8'h33); idle(100);
        wr_frame(8'h87, 8'h44); idle(100);
        wr_frame(8'h80, 8'h5A); idle(100);
        exp_regs[39:32] = 8'h11;
        exp_regs[47:40] = 8'h22;
        exp_regs[55:48] = 8'h33;
        exp_regs[63:56] = 8'h44;
        exp_regs[7:0]   = 8'h5A;
        check("preload_regs", reg_q, exp_regs);
        status_in = 8'hA5;

        // Burst read 5 bytes from 0x04
        exp_rd[0] = 8'h11;
        exp_rd[1] = 8'h22;
        exp_rd[2] = 8'h33;
        exp_rd[3] = 8'h44;
        exp_rd[4] = 8'h00;
        spi_byte(8'h04, rx);
        spi_byte(8'h05, rx);
        for (int k = 0; k < 5; k++) begin
            spi_byte(8'h00, rx);
            check($sformatf("burst_byte%0d", k), rx, exp_rd[k]);
        end
        check("burst_poci_done", poci, 0);
        idle(100);

        // Status read
        spi_byte(8'h03, rx);
        spi_byte(8'h01, rx);
        spi_byte(8'h00, rx);
        check("status_read", rx, 8'hA5);
        idle(100);

        // Write to status is dropped
        w0 = wr_cnt;
        wr_frame(8'h83, 8'hFF);
        check("status_wr_strobes", wr_cnt - w0, 0);
        check("status_wr_regs", reg_q, exp_regs);
        idle(100);

        // Out-of-range read then address wrap to 0
        spi_byte(8'h7F, rx);
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        check("oor_read", rx, 8'h00);
        spi_byte(8'h00, rx);
        check("wrap_read", rx, 8'h5A);
        idle(100);

        // Partial write then timeout
        w0 = wr_cnt;
        a0 = abort_cnt;
        spi_byte(8'h81, rx);
        spi_bit(1'b1, rb);
        spi_bit(1'b0, rb);
        spi_bit(1'b1, rb);
        idle(100);
        check("abort_pulses", abort_cnt - a0, 1);
        check("abort_no_strobe", wr_cnt - w0, 0);
        check("abort_regs", reg_q, exp_regs);
        check("abort_busy", busy, 0);
        w0 = wr_cnt;
        wr_frame(8'h81, 8'h3C);
        exp_regs[15:8] = 8'h3C;
        check("after_abort_regs", reg_q, exp_regs);
        check("after_abort_strobes", wr_cnt - w0, 1);
        idle(100);

        // Reset during a burst read
        a0 = abort_cnt;
        spi_byte(8'h04, rx);
        spi_byte(8'h05, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        spi_bit(1'b0, rb);
        spi_bit(1'b0, rb);
        spi_bit(1'b0, rb);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        exp_regs = '0;
        check("midrst_reg_q", reg_q, exp_regs);
        check("midrst_poci", poci, 0);
        check("midrst_inst", inst_pulse, 0);
        check("midrst_wr_strobe", wr_strobe, 0);
        check("midrst_wr_addr", wr_addr, 0);
        check("midrst_abort", frame_abort, 0);
        check("midrst_busy", busy, 0);
        idle(100);
        check("midrst_no_abort", abort_cnt - a0, 0);

        w0 = wr_cnt;
        wr_frame(8'h85, 8'h77);
        exp_regs[47:40] = 8'h77;
        check("post_rst_regs", reg_q, exp_regs);
        check("post_rst_wr_addr", wr_addr, 7'd5);
        check("post_rst_strobes", wr_cnt - w0, 1);
        idle(100);
        spi_byte(8'h05, rx);
        spi_byte(8'h01, rx);
        spi_byte(8'h00, rx);
        check("post_rst_read", rx, 8'h77);
        idle(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
